// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer and scoreboard for the encoder -> channel -> Viterbi decoder chain.
// Streams one payload frame plus flush zeros, schedules channel errors and counts residual bit errors.
module viterbi_frame_ctrl #(
  parameter int          FRAME_LEN = 256,
  parameter int          TAIL_LEN  = 2,
  parameter int          DEC_LAT   = 32,
  parameter int          ERR_N     = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        err_en_i,
  input  logic        src_valid_i,
  input  logic        src_bit_i,
  output logic        src_ready_o,
  output logic        enc_enable_o,
  output logic        enc_bit_o,
  output logic [1:0]  err_mask_o,
  output logic        dec_enable_o,
  input  logic        dec_bit_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] inj_ct_o,
  output logic [15:0] bit_err_ct_o
);

  localparam int IDXW = $clog2(FRAME_LEN + 1);
  localparam int MW   = $clog2(FRAME_LEN);
  localparam int TW   = (TAIL_LEN < 2) ? 1 : $clog2(TAIL_LEN);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(FRAME_LEN - 1);
  localparam logic [IDXW-1:0] FRAME_CNT = IDXW'(FRAME_LEN);
  localparam logic [TW-1:0]   TAIL_LAST = TW'(TAIL_LEN - 1);
  localparam logic [15:0]     LOW_MASK  = 16'((32'd1 << ERR_N) - 32'd1);
  localparam logic [15:0]     TAPS      = 16'hB400;

  typedef enum logic [2:0] {IDLE, SEND, TAIL, DRAIN, DONE} state_t;

  state_t              state;
  logic [IDXW-1:0]     bit_idx;
  logic [IDXW-1:0]     cmp_idx;
  logic [TW-1:0]       tail_cnt;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_next;
  logic                err_en_q;
  logic [DEC_LAT-1:0]  dly;
  logic                mem [0:FRAME_LEN-1];
  logic                accept;
  logic                dec_valid;
  logic                cmp_hit;
  logic                mismatch;
  logic [1:0]          new_mask;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign src_ready_o = (state == SEND);
  assign busy_o      = (state != IDLE);
  assign accept      = src_ready_o && src_valid_i;
  assign lfsr_next   = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ TAPS) : {1'b0, lfsr[15:1]};
  assign new_mask    = (err_en_q && ((lfsr & LOW_MASK) < 16'd2)) ? lfsr[ERR_N+1:ERR_N] : 2'b00;
  assign dec_valid   = dly[DEC_LAT-1];
  assign cmp_hit     = dec_valid && (cmp_idx < FRAME_CNT);
  assign mismatch    = dec_bit_i ^ mem[cmp_idx[MW-1:0]];

  // Payload store; the scoreboard reads it back in the same order it was accepted.
  always_ff @(posedge clk) begin
    if (accept) mem[bit_idx[MW-1:0]] <= src_bit_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_idx      <= '0;
      cmp_idx      <= '0;
      tail_cnt     <= '0;
      lfsr         <= SEED;
      err_en_q     <= 1'b0;
      dly          <= '0;
      enc_enable_o <= 1'b0;
      enc_bit_o    <= 1'b0;
      err_mask_o   <= 2'b00;
      dec_enable_o <= 1'b0;
      done_o       <= 1'b0;
      inj_ct_o     <= '0;
      bit_err_ct_o <= '0;
    end else begin
      lfsr         <= lfsr_next;
      dec_enable_o <= enc_enable_o;
      enc_enable_o <= 1'b0;
      err_mask_o   <= 2'b00;
      done_o       <= 1'b0;
      for (int i = DEC_LAT - 1; i > 0; i--) dly[i] <= dly[i-1];
      dly[0] <= enc_enable_o;

      // Alignment follows the enable delay line, so gaps in the source never skew the compare.
      if (cmp_hit) begin
        cmp_idx <= cmp_idx + 1'b1;
        if (mismatch) bit_err_ct_o <= sat_inc(bit_err_ct_o);
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state        <= SEND;
            bit_idx      <= '0;
            cmp_idx      <= '0;
            inj_ct_o     <= '0;
            bit_err_ct_o <= '0;
            lfsr         <= SEED;
            err_en_q     <= err_en_i;
          end
        end
        SEND: begin
          if (accept) begin
            bit_idx      <= bit_idx + 1'b1;
            enc_enable_o <= 1'b1;
            enc_bit_o    <= src_bit_i;
            err_mask_o   <= new_mask;
            if (new_mask != 2'b00) inj_ct_o <= sat_inc(inj_ct_o);
            if (bit_idx == LAST_IDX) begin
              tail_cnt <= '0;
              state    <= (TAIL_LEN == 0) ? DRAIN : TAIL;
            end
          end
        end
        TAIL: begin
          enc_enable_o <= 1'b1;
          enc_bit_o    <= 1'b0;
          tail_cnt     <= tail_cnt + 1'b1;
          if (tail_cnt == TAIL_LAST) state <= DRAIN;
        end
        DRAIN: begin
          if (!enc_enable_o && (dly == '0)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
